// File: rtl/pwm_dac_pkg.sv
// -----------------------------------------------------------------------------
// pwm_dac_pkg
// Shared definitions for the PWM DAC: the default sample width, the midscale
// duty value loaded at reset, and the IDLE/RUN state encoding.
// No ports.
// -----------------------------------------------------------------------------
package pwm_dac_pkg;

    localparam int PWM_WIDTH_DEF = 8;

    // Midscale duty (50 %) for the default width, used as the reset duty so
    // the output idles at mid-rail until the first sample arrives.
    localparam logic [PWM_WIDTH_DEF-1:0] MIDSCALE = 8'h80;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : pwm_dac_pkg

// File: rtl/pwm_dac_tick_gen.sv
// -----------------------------------------------------------------------------
// pwm_tick_gen
// Prescaler for the PWM counter. Emits one tick at the end of every
// PRESCALE-cycle window while run is high; the prescale count is held at 0
// whenever run is low, so a fresh run always begins a full window.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   run  - prescaler enable
//   tick - one-cycle step strobe for the PWM counter
// -----------------------------------------------------------------------------
module pwm_tick_gen
    import pwm_dac_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam logic [15:0] TC = 16'(PRESCALE - 1);

    logic [15:0] pre_q;
    logic [15:0] pre_d;

    always_comb begin
        pre_d = pre_q;
        if (!run || (pre_q == TC)) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // With PRESCALE=1 the terminal count is 0, so tick follows run directly.
    assign tick = run && (pre_q == TC);

endmodule : pwm_tick_gen

// File: rtl/pwm_dac.sv
// -----------------------------------------------------------------------------
// pwm_dac
// Sample-fed PWM DAC. Samples land in a one-deep holding register and are
// promoted to the active duty at each period wrap. A wrap with nothing held
// is an underrun: duty is kept, a sticky flag is set and (optionally) a
// saturating 16-bit counter increments.
//
// Build option: define PWM_DAC_UNDERRUN_CNT_EN to build the underrun counter;
// without it underrun_cnt is tied to 0 (the underrun flag is always present).
//
// Ports:
//   clk          - system clock
//   rst          - asynchronous active-low reset
//   enable       - run request; low returns to IDLE
//   sample_in    - unsigned sample
//   sample_valid - sample_in offered this cycle
//   sample_ready - holding register empty
//   pwm_out      - registered PWM bit
//   period_done  - one-cycle pulse on period wrap
//   underrun     - sticky underrun flag, cleared only by reset
//   underrun_cnt - saturating underrun count
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | output low, counter and prescaler cleared; samples still accepted
// RUN   | counting; pwm_out = (cnt < duty); duty reloaded at each wrap
// -----------------------------------------------------------------------------
module pwm_dac
    import pwm_dac_pkg::*;
#(
    parameter int WIDTH    = PWM_WIDTH_DEF,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             pwm_out,
    output logic             period_done,
    output logic             underrun,
    output logic [15:0]      underrun_cnt
);

    localparam logic [WIDTH-1:0] DUTY_RST = (WIDTH == PWM_WIDTH_DEF) ?
                                            WIDTH'(MIDSCALE) :
                                            {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;
    logic             pwm_q;
    logic             period_done_q;
    logic             underrun_q;

    logic run;
    logic tick;
    logic wrap;
    logic accept;

    // Dropping enable takes effect on the very next edge, so the last RUN
    // cycle already behaves as idle: no tick, no wrap, output forced low.
    assign run    = (state_q == RUN) && enable;
    assign wrap   = tick && (cnt_q == '1);
    assign accept = sample_valid && !hold_full_q;

    pwm_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .tick (tick)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            duty_q        <= DUTY_RST;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            pwm_q         <= 1'b0;
            period_done_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE:    if (enable)  state_q <= RUN;
                RUN:     if (!enable) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            cnt_q         <= cnt_d;
            pwm_q         <= run && (cnt_q < duty_q);
            period_done_q <= wrap;

            // Accept only happens with hold empty, so it never collides with
            // a duty reload; a wrap in the accept cycle sees the empty hold.
            if (accept) begin
                hold_q      <= sample_in;
                hold_full_q <= 1'b1;
            end else if (wrap && hold_full_q) begin
                duty_q      <= hold_q;
                hold_full_q <= 1'b0;
            end

            if (wrap && !hold_full_q) begin
                underrun_q <= 1'b1;
            end
        end
    end

`ifdef PWM_DAC_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_cnt_q <= '0;
        end else if (wrap && !hold_full_q && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
        end
    end

    assign underrun_cnt = underrun_cnt_q;
`else
    assign underrun_cnt = 16'd0;
`endif

    assign sample_ready = !hold_full_q;
    assign pwm_out      = pwm_q;
    assign period_done  = period_done_q;
    assign underrun     = underrun_q;

endmodule : pwm_dac

// File: tb/tb_pwm_dac.sv
module tb_pwm_dac;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       en, sv, rdy, pwm, pd, ur;
    logic [7:0] sin;
    logic [15:0] urc;

    logic       en4, sv4, rdy4, pwm4, pd4, ur4;
    logic [7:0] sin4;
    logic [15:0] urc4;

    always #5 clk = ~clk;

    pwm_dac #(.WIDTH(8), .PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .enable(en), .sample_in(sin), .sample_valid(sv),
        .sample_ready(rdy), .pwm_out(pwm), .period_done(pd), .underrun(ur),
        .underrun_cnt(urc)
    );

    pwm_dac #(.WIDTH(8), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .enable(en4), .sample_in(sin4), .sample_valid(sv4),
        .sample_ready(rdy4), .pwm_out(pwm4), .period_done(pd4), .underrun(ur4),
        .underrun_cnt(urc4)
    );

`ifdef PWM_DAC_UNDERRUN_CNT_EN
    localparam bit URC_EN = 1'b1;
`else
    localparam bit URC_EN = 1'b0;
`endif

    typedef struct {
        string name;
        int    hi;
        int    ur;
        int    urc;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    int n_tests = 0;
    int n_fail  = 0;
    int hi1 = 0;
    int hi4 = 0;
    bit clr1 = 1'b0;
    bit clr4 = 1'b0;

    function automatic int urc_exp(input int n);
        return URC_EN ? n : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push1(input string name, input int hi, input int u, input int c);
        exp_t e;
        e.name = name; e.hi = hi; e.ur = u; e.urc = c;
        q1.push_back(e);
    endtask

    task automatic push4(input string name, input int hi, input int u, input int c);
        exp_t e;
        e.name = name; e.hi = hi; e.ur = u; e.urc = c;
        q4.push_back(e);
    endtask

    // Waits for period_done of the selected DUT; n = negedges consumed.
    task automatic wait_pd(input bit four, input int budget, output int n);
        logic p;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            p = four ? pd4 : pd;
        end while (p !== 1'b1 && n < budget);
        if (p !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_pd%0d: no period_done after %0d cycles", four ? 4 : 1, n);
        end
    endtask

    // Monitor for the PRESCALE=1 DUT: counts high cycles over each period and
    // compares against the queued expectation on every period_done.
    always @(negedge clk) begin
        exp_t e;
        if (clr1) begin
            hi1 = 0;
            clr1 = 1'b0;
        end
        hi1 += int'(pwm);
        if (pd === 1'b1) begin
            if (q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL mon1_unexpected_period: got period_done, expected none");
            end else begin
                e = q1.pop_front();
                check({e.name, "_hi"},  hi1,       e.hi);
                check({e.name, "_ur"},  int'(ur),  e.ur);
                check({e.name, "_urc"}, int'(urc), e.urc);
            end
            hi1 = 0;
        end
    end

    // Monitor for the PRESCALE=4 DUT.
    always @(negedge clk) begin
        exp_t e;
        if (clr4) begin
            hi4 = 0;
            clr4 = 1'b0;
        end
        hi4 += int'(pwm4);
        if (pd4 === 1'b1) begin
            if (q4.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL mon4_unexpected_period: got period_done, expected none");
            end else begin
                e = q4.pop_front();
                check({e.name, "_hi"},  hi4,        e.hi);
                check({e.name, "_ur"},  int'(ur4),  e.ur);
                check({e.name, "_urc"}, int'(urc4), e.urc);
            end
            hi4 = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt_pd;
        en = 0; sv = 0; sin = '0;
        en4 = 0; sv4 = 0; sin4 = '0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pwm", int'(pwm), 0);
        check("rst_pd",  int'(pd),  0);
        check("rst_ur",  int'(ur),  0);
        check("rst_urc", int'(urc), 0);
        check("rst_rdy", int'(rdy), 1);
        @(posedge clk); #1 rst = 1'b1;

        // No samples: midscale duty, underrun at first wrap.
        push1("p1_nosample", 128, 1, urc_exp(1));
        @(posedge clk); #1 en = 1'b1;
        wait_pd(1'b0, 400, n);

        // Accept 0x40 mid-period; applied from the next period.
        push1("p2_accept_mid", 128, 1, urc_exp(1));
        repeat (100) @(posedge clk);
        #1 sv = 1'b1; sin = 8'h40;
        @(negedge clk) check("rdy_before_accept", int'(rdy), 1);
        @(posedge clk); #1 sv = 1'b0;
        @(negedge clk) check("rdy_after_accept", int'(rdy), 0);
        repeat (100) @(negedge clk);
        check("rdy_held_full", int'(rdy), 0);
        wait_pd(1'b0, 400, n);
        check("rdy_after_wrap", int'(rdy), 1);

        // Offer 0x00 in the wrap cycle with hold empty.
        push1("p3_duty40", 64, 1, urc_exp(2));
        repeat (255) @(posedge clk);
        #1 sv = 1'b1; sin = 8'h00;
        @(negedge clk) check("rdy_wrap_cycle", int'(rdy), 1);
        @(posedge clk); #1 sv = 1'b0;
        wait_pd(1'b0, 10, n);
        check("wrap_accept_hold_full", int'(rdy), 0);
        check("wrap_accept_urc", int'(urc), urc_exp(2));

        push1("p4_duty40_kept", 64, 1, urc_exp(2));
        wait_pd(1'b0, 400, n);

        push1("p5_duty00", 0, 1, urc_exp(2));
        repeat (10) @(posedge clk);
        #1 sv = 1'b1; sin = 8'hFF;
        @(posedge clk); #1 sv = 1'b0;
        wait_pd(1'b0, 400, n);

        push1("p6_dutyFF", 255, 1, urc_exp(3));
        wait_pd(1'b0, 300, n);
        check("period_len_256", n, 256);

        // Reset mid-period with hold full.
        repeat (20) @(posedge clk);
        #1 sv = 1'b1; sin = 8'h10;
        @(posedge clk); #1 sv = 1'b0;
        @(negedge clk) check("p7_hold_full", int'(rdy), 0);
        check("p7_pwm_high", int'(pwm), 1);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        check("mid_rst_pwm", int'(pwm), 0);
        check("mid_rst_ur",  int'(ur),  0);
        check("mid_rst_urc", int'(urc), 0);
        check("mid_rst_rdy", int'(rdy), 1);
        en = 1'b0;
        clr1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        push1("p_after_rst_midscale", 128, 1, urc_exp(1));
        @(posedge clk); #1 en = 1'b1;
        wait_pd(1'b0, 400, n);
        @(posedge clk); #1 en = 1'b0;

        // PRESCALE=4 instance: sample accepted while idle.
        @(posedge clk); #1 sv4 = 1'b1; sin4 = 8'h80;
        @(posedge clk); #1 sv4 = 1'b0;
        @(negedge clk) check("p4x_idle_accept", int'(rdy4), 0);
        push4("p4x_1", 512, 0, 0);
        @(posedge clk); #1 en4 = 1'b1;
        wait_pd(1'b1, 1200, n);
        push4("p4x_2", 512, 1, urc_exp(1));
        wait_pd(1'b1, 1200, n);
        check("p4x_period_len", n, 1024);

        // Abort at cnt=0x30.
        repeat (192) @(posedge clk);
        #1 en4 = 1'b0;
        @(negedge clk) check("p4x_pwm_before_drop", int'(pwm4), 1);
        @(negedge clk) check("p4x_pwm_after_drop", int'(pwm4), 0);
        cnt_pd = 0;
        repeat (1100) begin
            @(negedge clk);
            if (pd4 === 1'b1) cnt_pd++;
        end
        check("p4x_no_pd_on_abort", cnt_pd, 0);
        clr4 = 1'b1;

        push4("p4x_restart", 512, 1, urc_exp(2));
        @(posedge clk); #1 en4 = 1'b1;
        wait_pd(1'b1, 1200, n);
        check("p4x_restart_len", n, 1026);

        repeat (3) @(negedge clk);
        check("q1_drained", q1.size(), 0);
        check("q4_drained", q4.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pwm_dac
